counter_down_sync_16: RTL and testbench

Loadable 16-bit synchronous down counter/timer: the counting-down counterpart to the team's 16-bit up counter. It accepts a start value through a valid/ready load handshake, then decrements on prescaled ticks. At zero it emits a one-cycle terminal-count pulse and either stops (one-shot) or reloads (periodic). It serves as the timeout/interval generator beside the up counters in the counter library.

---
 rtl/counter_down_sync_16_pkg.sv | 17 +
 rtl/counter_down_sync_16_tick_prescaler.sv | 64 ++++++
 rtl/counter_down_sync_16.sv | 143 ++++++++++++++
 tb/tb_counter_down_sync_16.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_down_sync_16_pkg.sv
// -----------------------------------------------------------------------------
// counter_down_sync_16_pkg
// Shared definitions for the counter library: default counter and prescaler
// widths (common to the up- and down-counter family) and the IDLE/RUN state
// encoding used by the loadable counters.
// -----------------------------------------------------------------------------
package counter_down_sync_16_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT  = 16;
    localparam int unsigned PRESCALE_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cnt_state_e;

endpackage : counter_down_sync_16_pkg

// File: rtl/counter_down_sync_16_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides enabled cycles by P+1: tick_o is high on the enabled cycle in which
// the internal count equals prescale_i, and the count then wraps to zero.
// A low enable_i freezes the count. clear_i forces the count back to zero.
//
// Ports:
//   clk_i       clock, all logic on the rising edge
//   reset_i     synchronous active-high reset
//   clear_i     synchronous clear of the prescale count
//   enable_i    count enable
//   prescale_i  divider value P (tick every P+1 enabled cycles)
//   tick_o      tick strobe, valid in the same cycle as the matching count
// -----------------------------------------------------------------------------
module tick_prescaler
    import counter_down_sync_16_pkg::*;
#(
    parameter int unsigned PRESCALE_W = PRESCALE_W_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    localparam logic [PRESCALE_W-1:0] PCNT_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PCNT_ONE  = PRESCALE_W'(1'b1);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;
    logic                  tick_s;

    // Next prescale count and tick decode.
    always_comb begin
        pcnt_d = pcnt_q;
        tick_s = 1'b0;
        if (clear_i) begin
            pcnt_d = PCNT_ZERO;
        end else if (enable_i) begin
            if (pcnt_q == prescale_i) begin
                tick_s = 1'b1;
                pcnt_d = PCNT_ZERO;
            end else begin
                pcnt_d = pcnt_q + PCNT_ONE;
            end
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // Prescale count register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pcnt_q <= PCNT_ZERO;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign tick_o = tick_s;

endmodule : tick_prescaler

// File: rtl/counter_down_sync_16.sv
// -----------------------------------------------------------------------------
// counter_down_sync_16
// Loadable down counter / timer. A start value is accepted through a
// valid/ready handshake while IDLE; in RUN the count decrements on each
// prescaled tick. A tick at zero is the terminal tick: tc_o pulses for one
// cycle afterwards and the counter either reloads (periodic) or stops in IDLE
// holding zero (one-shot). abort_i returns to IDLE, holding the count and
// suppressing any coincident terminal pulse.
//
// Ports:
//   clk_i         clock, all logic on the rising edge
//   reset_i       synchronous active-high reset (priority over everything)
//   load_valid_i  load request
//   load_ready_o  load can be accepted (IDLE)
//   load_value_i  start/reload value, sampled on acceptance
//   periodic_i    1: reload at terminal, 0: one-shot; sampled on acceptance
//   prescale_i    tick divider P, sampled on acceptance
//   enable_i      count enable; low freezes prescaler and count
//   abort_i       stop counting and return to IDLE
//   q_o           current count
//   busy_o        counting (RUN)
//   tc_o          one-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module counter_down_sync_16
    import counter_down_sync_16_pkg::*;
#(
    parameter int unsigned WIDTH      = CNT_WIDTH_DEFAULT,
    parameter int unsigned PRESCALE_W = PRESCALE_W_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [WIDTH-1:0]      load_value_i,
    input  logic                  periodic_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  enable_i,
    input  logic                  abort_i,
    output logic [WIDTH-1:0]      q_o,
    output logic                  busy_o,
    output logic                  tc_o
);

    localparam logic [WIDTH-1:0]      Q_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      Q_ONE   = WIDTH'(1'b1);
    localparam logic [PRESCALE_W-1:0] PS_ZERO = {PRESCALE_W{1'b0}};

    cnt_state_e            state_q,    state_d;
    logic [WIDTH-1:0]      q_q,        q_d;
    logic [WIDTH-1:0]      reload_q,   reload_d;
    logic                  periodic_q, periodic_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  tc_q,       tc_d;

    logic                  load_accept_s;
    logic                  pre_enable_s;
    logic                  tick_s;

    assign load_accept_s = load_valid_i & (state_q == ST_IDLE);
    assign pre_enable_s  = enable_i & (state_q == ST_RUN);

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_prescaler (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (load_accept_s),
        .enable_i   (pre_enable_s),
        .prescale_i (prescale_q),
        .tick_o     (tick_s)
    );

    // Next-state, count and terminal-pulse logic.
    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        prescale_d = prescale_q;
        tc_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid_i) begin
                    q_d        = load_value_i;
                    reload_d   = load_value_i;
                    periodic_d = periodic_i;
                    prescale_d = prescale_i;
                    state_d    = ST_RUN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Abort outranks a coincident tick, so no tc and Q holds.
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    if (q_q != Q_ZERO) begin
                        q_d = q_q - Q_ONE;
                    end else begin
                        tc_d = 1'b1;
                        if (periodic_q) begin
                            q_d = reload_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, count, captured-configuration and tc registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            q_q        <= Q_ZERO;
            reload_q   <= Q_ZERO;
            periodic_q <= 1'b0;
            prescale_q <= PS_ZERO;
            tc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            prescale_q <= prescale_d;
            tc_q       <= tc_d;
        end
    end

    // Handshake/status decode straight from the state register.
    assign load_ready_o = (state_q == ST_IDLE);
    assign busy_o       = (state_q == ST_RUN);
    assign q_o          = q_q;
    assign tc_o         = tc_q;

endmodule : counter_down_sync_16

// File: tb/tb_counter_down_sync_16.sv
module tb_counter_down_sync_16;

    typedef struct packed {
        logic [15:0] q;
        logic        tc;
        logic        busy;
        logic        ready;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_value = 16'h0000;
    logic        periodic = 1'b0;
    logic [7:0]  prescale = 8'h00;
    logic        enable = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] q;
    logic        busy;
    logic        tc;

    obs_t sb[$];
    obs_t got;
    obs_t want;
    int   checks = 0;
    int   failures = 0;

    counter_down_sync_16 dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready),
        .load_value_i (load_value),
        .periodic_i   (periodic),
        .prescale_i   (prescale),
        .enable_i     (enable),
        .abort_i      (abort),
        .q_o          (q),
        .busy_o       (busy),
        .tc_o         (tc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        load_valid = 1'b1;
        load_value = 16'h00AA;
        sb.push_back('{16'h0000, 1'b0, 1'b0, 1'b1});
        sb.push_back('{16'h0000, 1'b0, 1'b0, 1'b1});
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            got = {q, tc, busy, load_ready};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset k=%0d got q=%h tc=%b busy=%b ready=%b want q=%h tc=%b busy=%b ready=%b",
                         k, got.q, got.tc, got.busy, got.ready, want.q, want.tc, want.busy, want.ready);
            end
            if (k == 0) begin
                reset = 1'b0;
                load_valid = 1'b0;
            end
        end
    endtask

    task automatic test_oneshot();
        load_value = 16'd5; prescale = 8'd0; periodic = 1'b0; enable = 1'b1; load_valid = 1'b1;
        for (int i = 0; i <= 5; i++) sb.push_back('{16'(5 - i), 1'b0, 1'b1, 1'b0});
        sb.push_back('{16'h0000, 1'b1, 1'b0, 1'b1});
        sb.push_back('{16'h0000, 1'b0, 1'b0, 1'b1});
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            got = {q, tc, busy, load_ready};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL oneshot k=%0d got q=%h tc=%b busy=%b ready=%b want q=%h tc=%b busy=%b ready=%b",
                         k, got.q, got.tc, got.busy, got.ready, want.q, want.tc, want.busy, want.ready);
            end
            if (k == 0) load_valid = 1'b0;
        end
    endtask

    task automatic test_periodic();
        load_value = 16'd2; prescale = 8'd3; periodic = 1'b1; enable = 1'b1; load_valid = 1'b1;
        for (int i = 0; i <= 36; i++)
            sb.push_back('{16'(2 - ((i / 4) % 3)), (i != 0) && (i % 12 == 0), 1'b1, 1'b0});
        sb.push_back('{16'd2, 1'b0, 1'b0, 1'b1});
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            got = {q, tc, busy, load_ready};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL periodic k=%0d got q=%h tc=%b busy=%b ready=%b want q=%h tc=%b busy=%b ready=%b",
                         k, got.q, got.tc, got.busy, got.ready, want.q, want.tc, want.busy, want.ready);
            end
            if (k == 0) load_valid = 1'b0;
            if (k == 36) abort = 1'b1;
            if (k == 37) abort = 1'b0;
        end
        periodic = 1'b0;
    endtask

    task automatic test_enable_freeze();
        // Part 1: full-scale load, P=0, ten frozen cycles.
        load_value = 16'hFFFF; prescale = 8'd0; periodic = 1'b0; enable = 1'b1; load_valid = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i <= 5)       sb.push_back('{16'hFFFF - 16'(i), 1'b0, 1'b1, 1'b0});
            else if (i <= 15) sb.push_back('{16'hFFFA, 1'b0, 1'b1, 1'b0});
            else              sb.push_back('{16'hFFF9, 1'b0, 1'b1, 1'b0});
        end
        sb.push_back('{16'hFFF9, 1'b0, 1'b0, 1'b1});
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            got = {q, tc, busy, load_ready};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL enable_p0 k=%0d got q=%h tc=%b busy=%b ready=%b want q=%h tc=%b busy=%b ready=%b",
                         k, got.q, got.tc, got.busy, got.ready, want.q, want.tc, want.busy, want.ready);
            end
            if (k == 0)  load_valid = 1'b0;
            if (k == 5)  enable = 1'b0;
            if (k == 15) enable = 1'b1;
            if (k == 16) abort = 1'b1;
            if (k == 17) abort = 1'b0;
        end
        // Part 2: P=2, freeze in the middle of a prescale period.
        load_value = 16'd3; prescale = 8'd2; load_valid = 1'b1;
        for (int i = 0; i <= 9; i++)
            sb.push_back('{(i <= 5) ? 16'd3 : ((i <= 8) ? 16'd2 : 16'd1), 1'b0, 1'b1, 1'b0});
        sb.push_back('{16'd1, 1'b0, 1'b0, 1'b1});
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            got = {q, tc, busy, load_ready};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL enable_p2 k=%0d got q=%h tc=%b busy=%b ready=%b want q=%h tc=%b busy=%b ready=%b",
                         k, got.q, got.tc, got.busy, got.ready, want.q, want.tc, want.busy, want.ready);
            end
            if (k == 0)  load_valid = 1'b0;
            if (k == 1)  enable = 1'b0;
            if (k == 4)  enable = 1'b1;
            if (k == 9)  abort = 1'b1;
            if (k == 10) abort = 1'b0;
        end
    endtask

    task automatic test_abort_terminal();
        load_value = 16'd3; prescale = 8'd0; periodic = 1'b0; enable = 1'b1; load_valid = 1'b1;
        for (int i = 0; i <= 3; i++) sb.push_back('{16'(3 - i), 1'b0, 1'b1, 1'b0});
        sb.push_back('{16'h0000, 1'b0, 1'b0, 1'b1});
        sb.push_back('{16'h0000, 1'b0, 1'b0, 1'b1});
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            got = {q, tc, busy, load_ready};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL abort k=%0d got q=%h tc=%b busy=%b ready=%b want q=%h tc=%b busy=%b ready=%b",
                         k, got.q, got.tc, got.busy, got.ready, want.q, want.tc, want.busy, want.ready);
            end
            if (k == 0) load_valid = 1'b0;
            if (k == 3) abort = 1'b1;
            if (k == 4) abort = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        load_value = 16'd2; prescale = 8'd0; periodic = 1'b0; enable = 1'b1; load_valid = 1'b1;
        sb.push_back('{16'd2, 1'b0, 1'b1, 1'b0});
        sb.push_back('{16'd1, 1'b0, 1'b1, 1'b0});
        sb.push_back('{16'd0, 1'b0, 1'b1, 1'b0});
        sb.push_back('{16'd0, 1'b1, 1'b0, 1'b1});
        sb.push_back('{16'd9, 1'b0, 1'b1, 1'b0});
        sb.push_back('{16'd8, 1'b0, 1'b1, 1'b0});
        sb.push_back('{16'd8, 1'b0, 1'b0, 1'b1});
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            got = {q, tc, busy, load_ready};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL back_to_back k=%0d got q=%h tc=%b busy=%b ready=%b want q=%h tc=%b busy=%b ready=%b",
                         k, got.q, got.tc, got.busy, got.ready, want.q, want.tc, want.busy, want.ready);
            end
            if (k == 0) load_value = 16'd9;   // held request while RUN
            if (k == 4) load_valid = 1'b0;
            if (k == 5) abort = 1'b1;
            if (k == 6) abort = 1'b0;
        end
    endtask

    task automatic test_load_zero();
        load_value = 16'd0; prescale = 8'd1; periodic = 1'b1; enable = 1'b1; load_valid = 1'b1;
        for (int i = 0; i <= 6; i++) sb.push_back('{16'd0, (i >= 2) && (i % 2 == 0), 1'b1, 1'b0});
        sb.push_back('{16'd0, 1'b0, 1'b0, 1'b1});
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            got = {q, tc, busy, load_ready};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL load_zero k=%0d got q=%h tc=%b busy=%b ready=%b want q=%h tc=%b busy=%b ready=%b",
                         k, got.q, got.tc, got.busy, got.ready, want.q, want.tc, want.busy, want.ready);
            end
            if (k == 0) load_valid = 1'b0;
            if (k == 6) abort = 1'b1;
            if (k == 7) abort = 1'b0;
        end
        periodic = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        load_value = 16'h1235; prescale = 8'd0; periodic = 1'b1; enable = 1'b1; load_valid = 1'b1;
        sb.push_back('{16'h1235, 1'b0, 1'b1, 1'b0});
        sb.push_back('{16'h1234, 1'b0, 1'b1, 1'b0});
        sb.push_back('{16'h0000, 1'b0, 1'b0, 1'b1});
        sb.push_back('{16'h0000, 1'b0, 1'b0, 1'b1});
        sb.push_back('{16'h0000, 1'b0, 1'b0, 1'b1});
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            got = {q, tc, busy, load_ready};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid_run k=%0d got q=%h tc=%b busy=%b ready=%b want q=%h tc=%b busy=%b ready=%b",
                         k, got.q, got.tc, got.busy, got.ready, want.q, want.tc, want.busy, want.ready);
            end
            if (k == 0) load_valid = 1'b0;
            if (k == 1) begin
                reset = 1'b1;
                load_valid = 1'b1;            // reset outranks a pending load
                load_value = 16'h0077;
            end
            if (k == 3) begin
                reset = 1'b0;
                load_valid = 1'b0;
            end
        end
        periodic = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_enable_freeze();
        test_abort_terminal();
        test_back_to_back();
        test_load_zero();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_counter_down_sync_16
